// File: rtl/present_cipher_core.sv
// Iterative PRESENT-64 cipher engine: one round per clock, 80/128-bit key schedule computed on the fly.
// Define PRESENT_DECRYPT_EN to build the KEYEXP state and the inverse datapath used for decryption.
module present_cipher_core #(
    parameter int KEY_SIZE = 80,
    parameter int ROUNDS   = 31
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_decrypt,
    input  logic [KEY_SIZE-1:0] in_key,
    input  logic [63:0]         in_block,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         out_block,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} fsmState_t;

    localparam logic [4:0] LAST_RC = 5'(ROUNDS);

    generate
        if ((KEY_SIZE != 80 && KEY_SIZE != 128) || ROUNDS < 1 || ROUNDS > 31) begin : g_badParams
            $error("present_cipher_core: KEY_SIZE must be 80 or 128 and ROUNDS 1..31");
        end
    endgenerate

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] sboxLayer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
        return y;
    endfunction

    // Bit i moves to 16*(i mod 4) + i/4, which equals i*16 mod 63 with bit 63 fixed.
    function automatic logic [63:0] pLayer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[16*(i%4) + i/4] = x[i];
        return y;
    endfunction

    logic [4:0]          r_rc;
    logic [KEY_SIZE-1:0] r_key;
    logic [63:0]         r_state;
    logic [63:0]         r_outBlock;
    logic                r_outValid;
    logic                r_last;
    fsmState_t           r_fsm;

    logic [63:0]         w_addKey;
    logic [63:0]         w_encState;
    logic [KEY_SIZE-1:0] w_keyFwd;

    assign w_addKey   = r_state ^ r_key[KEY_SIZE-1 -: 64];
    assign w_encState = pLayer(sboxLayer(w_addKey));

`ifdef PRESENT_DECRYPT_EN
    function automatic logic [3:0] sboxInv(input logic [3:0] x);
        case (x)
            4'h0: sboxInv = 4'h5;  4'h1: sboxInv = 4'hE;  4'h2: sboxInv = 4'hF;  4'h3: sboxInv = 4'h8;
            4'h4: sboxInv = 4'hC;  4'h5: sboxInv = 4'h1;  4'h6: sboxInv = 4'h2;  4'h7: sboxInv = 4'hD;
            4'h8: sboxInv = 4'hB;  4'h9: sboxInv = 4'h4;  4'hA: sboxInv = 4'h6;  4'hB: sboxInv = 4'h3;
            4'hC: sboxInv = 4'h0;  4'hD: sboxInv = 4'h7;  4'hE: sboxInv = 4'h9;  default: sboxInv = 4'hA;
        endcase
    endfunction

    function automatic logic [63:0] sboxInvLayer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = sboxInv(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] pLayerInv(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[16*(i%4) + i/4];
        return y;
    endfunction

    logic                r_decrypt;
    logic [63:0]         w_decState;
    logic [KEY_SIZE-1:0] w_keyInv;

    assign w_decState = sboxInvLayer(pLayerInv(w_addKey));
`else
    logic w_unusedDecrypt;
    assign w_unusedDecrypt = in_decrypt;
`endif

    // Key schedule: the inverse undoes the forward step in reverse order (xor, S-box, rotate).
    generate
        if (KEY_SIZE == 128) begin : g_key128
            always_comb begin
                w_keyFwd           = {r_key[66:0], r_key[127:67]};
                w_keyFwd[127:124]  = sbox(w_keyFwd[127:124]);
                w_keyFwd[123:120]  = sbox(w_keyFwd[123:120]);
                w_keyFwd[66:62]    = w_keyFwd[66:62] ^ r_rc;
            end
`ifdef PRESENT_DECRYPT_EN
            logic [127:0] w_invTmp;
            always_comb begin
                w_invTmp           = r_key;
                w_invTmp[66:62]    = w_invTmp[66:62] ^ r_rc;
                w_invTmp[127:124]  = sboxInv(w_invTmp[127:124]);
                w_invTmp[123:120]  = sboxInv(w_invTmp[123:120]);
                w_keyInv           = {w_invTmp[60:0], w_invTmp[127:61]};
            end
`endif
        end else begin : g_key80
            always_comb begin
                w_keyFwd           = {r_key[18:0], r_key[79:19]};
                w_keyFwd[79:76]    = sbox(w_keyFwd[79:76]);
                w_keyFwd[19:15]    = w_keyFwd[19:15] ^ r_rc;
            end
`ifdef PRESENT_DECRYPT_EN
            logic [79:0] w_invTmp;
            always_comb begin
                w_invTmp           = r_key;
                w_invTmp[19:15]    = w_invTmp[19:15] ^ r_rc;
                w_invTmp[79:76]    = sboxInv(w_invTmp[79:76]);
                w_keyInv           = {w_invTmp[60:0], w_invTmp[79:61]};
            end
`endif
        end
    endgenerate

    // r_last marks that all rounds are done; the next ROUND cycle performs the final whitening.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_fsm      <= IDLE;
            r_state    <= '0;
            r_key      <= '0;
            r_rc       <= '0;
            r_last     <= 1'b0;
            r_outBlock <= '0;
            r_outValid <= 1'b0;
`ifdef PRESENT_DECRYPT_EN
            r_decrypt  <= 1'b0;
`endif
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= in_block;
                        r_key   <= in_key;
                        r_rc    <= 5'd1;
                        r_last  <= 1'b0;
`ifdef PRESENT_DECRYPT_EN
                        r_decrypt <= in_decrypt;
                        r_fsm     <= in_decrypt ? KEYEXP : ROUND;
`else
                        r_fsm     <= ROUND;
`endif
                    end
                end
`ifdef PRESENT_DECRYPT_EN
                KEYEXP: begin
                    r_key <= w_keyFwd;
                    if (r_rc == LAST_RC) r_fsm <= ROUND;
                    else                 r_rc  <= r_rc + 5'd1;
                end
`endif
                ROUND: begin
                    if (r_last) begin
                        r_outBlock <= w_addKey;
                        r_outValid <= 1'b1;
                        r_fsm      <= DONE;
                    end else begin
`ifdef PRESENT_DECRYPT_EN
                        if (r_decrypt) begin
                            r_state <= w_decState;
                            r_key   <= w_keyInv;
                            if (r_rc == 5'd1) r_last <= 1'b1;
                            else              r_rc   <= r_rc - 5'd1;
                        end else begin
`else
                        begin
`endif
                            r_state <= w_encState;
                            r_key   <= w_keyFwd;
                            if (r_rc == LAST_RC) r_last <= 1'b1;
                            else                 r_rc   <= r_rc + 5'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_fsm      <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == IDLE);
    assign busy      = (r_fsm != IDLE);
    assign out_valid = r_outValid;
    assign out_block = r_outBlock;

endmodule

// File: doc/present_cipher_core.md
# present_cipher_core

Iterative PRESENT block-cipher engine: one 64-bit block per transaction, one round per clock, with the round key expanded on the fly. Supports 80-bit and 128-bit keys and, when compiled in, decryption. Sits between the crypto register/DMA front end and the stream wrapper. Valid/ready handshakes on both sides replace the free-running counter and `Done` pulse used by the earlier encrypt-only datapath.

## Interface
Parameters:
- `KEY_SIZE`, default 80: key width. Legal values are 80 or 128; any other value is an elaboration error.
- `ROUNDS`, default 31: number of full rounds. The final key whitening is an additional step.

Ports:
- `Clock`, in, 1: single clock; all state changes on the rising edge.
- `Reset`, in, 1: asynchronous, active-high. Clears all state immediately.
- `in_valid`, in, 1: request present.
- `in_ready`, out, 1: core is idle and accepts a request.
- `in_decrypt`, in, 1: 1 selects decrypt, 0 selects encrypt. Sampled at accept.
- `in_key`, in, KEY_SIZE: cipher key. Sampled at accept.
- `in_block`, in, 64: plaintext or ciphertext. Sampled at accept.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: consumer accepts the result.
- `out_block`, out, 64: result.
- `busy`, out, 1: FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On accept (`in_valid && in_ready`), go to ROUND for encrypt or KEYEXP for decrypt.
  - KEYEXP: runs the forward key schedule only; state register unchanged.
  - ROUND: performs one round per cycle.
  - DONE: holds `out_valid`; goes to IDLE on `out_ready`.
- Accept: `state`←`in_block`, `key`←`in_key`, round counter `rc`←1.
- Forward key update:
  - KEY_SIZE 80: rotate left 61, S-box on bits [79:76], bits [19:15] ^= `rc`.
  - KEY_SIZE 128: rotate left 61, S-box on [127:124] and [123:120], bits [66:62] ^= `rc`.
- Inverse key update: the exact inverse of the forward update. XOR with `rc`, then inverse S-box on the same nibbles, then rotate right 61.
- Round key = top 64 bits of `key`.
- Encrypt round: `state`←P(S(`state`^rk)), forward key update, `rc`++.
- Decrypt round: `state`←S⁻¹(P⁻¹(`state`^rk)), inverse key update using `rc`, `rc`--.
- Encrypt sequence: ROUNDS rounds, then `out_block`←`state`^rk(K32), then DONE.
- Decrypt sequence:
  - KEYEXP runs ROUNDS forward updates (`rc` 1..31); `rc` ends at 31.
  - ROUND then uses keys K32 down to K2.
  - Finally `out_block`←`state`^rk(K1), then DONE.
- `rc` is 5 bits. Its value never wraps: the counter is checked for 31 before the increment.
- `in_valid` while busy is ignored; no queuing.
- `in_key`, `in_block` and `in_decrypt` may change freely after accept.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_block`=0, `busy`=0, FSM=IDLE, `state`/`key`/`rc`=0.
- Call the accept edge edge 0.
- Encrypt:
  - Rounds occur on edges 1..31.
  - Whitening and `out_valid` rise on edge 32; latency is 32 cycles.
- Decrypt:
  - KEYEXP occupies edges 1..31.
  - Rounds occur on edges 32..62.
  - Whitening and `out_valid` rise on edge 63; latency is 63 cycles.
- `out_valid`/`out_block` stay stable until the edge where `out_ready`=1.
  - That edge clears `out_valid` and returns the FSM to IDLE.
  - `in_ready` rises after that edge; no same-cycle turnaround.
- `out_ready` asserted before `out_valid` has no effect.
- `Reset` asserted mid-operation aborts the operation: the result is discarded and nothing is emitted after release.
- `in_ready` is a function of FSM state only. It never depends combinationally on `in_valid`.

## Configuration
- `PRESENT_DECRYPT_EN` defined:
  - KEYEXP state, inverse S-box/P-layer and inverse key update are present.
  - `in_decrypt`=1 performs decryption.
- Not defined:
  - Those blocks are absent.
  - `in_decrypt` is ignored, and every request is encrypted with 32-cycle latency.

## Test plan
- KEY_SIZE 80 encrypt:
  - key 0, pt 0 → 5579C1387B228445.
  - key all-F, pt all-F → 3333DCD3213210D2.
  - Check that `out_valid` rises exactly 32 cycles after accept.
- KEY_SIZE 80 encrypt, key all-F, pt 0 → E72C46C0F5945049. Hold `out_ready`=0 for 10 cycles; `out_block` must stay stable and `in_ready` must stay 0.
- KEY_SIZE 128, key 0, pt 0 → 96DB702A2E6900AF.
- With `PRESENT_DECRYPT_EN`:
  - Decrypt key 0, ct 5579C1387B228445 → 0, with latency 63.
  - Round-trip 1000 random key/block pairs for each KEY_SIZE.
- Assert `Reset` at edge 15 of an encrypt:
  - `out_valid` stays 0 and `in_ready`=1 after release.
  - The next request (key 0, pt 0) yields 5579C1387B228445.
- Back-to-back requests with `in_valid` held high:
  - The second request is accepted only after the first result handshakes.
  - `in_block` changes while busy must not affect the result.
